// File: rtl/readback_frame_capture_if.sv
// Readback stream in (word + valid/ready) and frame-buffer write port out.
// The slave side is the capture block; the master side feeds words and observes writes.
interface readback_frame_capture_if #(
    parameter int ADDR_W = 13
) ();
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       data_output;

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, write_addr, data_output
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, write_addr, data_output
    );
endinterface

// File: rtl/readback_frame_capture.sv
// Captures one ICAP readback frame: drops the leading dummy/pad words, optionally
// bit-reverses each byte, and writes the kept words to the frame BRAM at 0..TOTAL_WORDS-1.
module readback_frame_capture #(
    parameter int SKIP_WORDS  = 102,
    parameter int TOTAL_WORDS = 303,
    parameter int ADDR_W      = 13,
    parameter int BIT_SWAP    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm_i,
    input  logic                      abort_i,
    readback_frame_capture_if.slave   bus,
    output logic                      flip_start_o,
    output logic                      busy_o,
    output logic                      capture_done_o,
    output logic [ADDR_W-1:0]         word_count_o
);
    localparam int DATA_W = 32;
    localparam int SKIP_W = (SKIP_WORDS > 1) ? $clog2(SKIP_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_DONE
    } state_e;

    // With no words to skip, arm goes straight to capture.
    localparam state_e            ARM_TARGET = (SKIP_WORDS == 0) ? S_CAPTURE : S_SKIP;
    localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'((SKIP_WORDS > 0) ? SKIP_WORDS - 1 : 0);
    localparam logic [ADDR_W-1:0] WORD_LAST  = ADDR_W'(TOTAL_WORDS - 1);

    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_en_q, wr_en_d;
    logic                active;
    logic                beat;

    function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
        if (BIT_SWAP != 0) begin
            for (int k = 0; k < DATA_W / 8; k++) begin
                for (int i = 0; i < 8; i++) begin
                    r[8*k+i] = w[8*k+7-i];
                end
            end
        end
        return r;
    endfunction

    // in_ready depends on state alone so the upstream never sees a combinational loop.
    assign active = (state_q == S_SKIP) || (state_q == S_CAPTURE);
    assign beat   = bus.in_valid & active;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_i && !abort_i) begin
                    state_d    = ARM_TARGET;
                    skip_cnt_d = '0;
                    word_cnt_d = '0;
                    waddr_d    = '0;
                end
            end
            S_SKIP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    wr_en_d    = 1'b1;
                    data_d     = swap_bytes(bus.in_data);
                    waddr_d    = word_cnt_q;
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (word_cnt_q == WORD_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            skip_cnt_q <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign bus.in_ready    = active;
    assign bus.wr_en       = wr_en_q;
    assign bus.write_addr  = waddr_q;
    assign bus.data_output = data_q;
    assign flip_start_o    = active;
    assign busy_o          = active;
    assign capture_done_o  = (state_q == S_DONE);
    assign word_count_o    = word_cnt_q;
endmodule

// File: tb/tb_readback_frame_capture.sv
// Drives two captures (byte swap off and on) with one stimulus stream and scores both
// against a word-counting reference model of the capture rules.
module tb_readback_frame_capture;
    localparam int SKIP  = 2;
    localparam int TOTAL = 4;
    localparam int AW    = 13;

    logic clk = 1'b0;
    logic rst;
    logic arm;
    logic abort;
    logic flip0, busy0, done0, flip1, busy1, done1;
    logic [AW-1:0] wc0, wc1;

    int tests = 0;
    int fails = 0;

    readback_frame_capture_if #(.ADDR_W(AW)) if0 ();
    readback_frame_capture_if #(.ADDR_W(AW)) if1 ();

    readback_frame_capture #(
        .SKIP_WORDS(SKIP), .TOTAL_WORDS(TOTAL), .ADDR_W(AW), .BIT_SWAP(0)
    ) u0 (
        .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort), .bus(if0.slave),
        .flip_start_o(flip0), .busy_o(busy0), .capture_done_o(done0), .word_count_o(wc0)
    );

    readback_frame_capture #(
        .SKIP_WORDS(SKIP), .TOTAL_WORDS(TOTAL), .ADDR_W(AW), .BIT_SWAP(1)
    ) u1 (
        .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort), .bus(if1.slave),
        .flip_start_o(flip1), .busy_o(busy1), .capture_done_o(done1), .word_count_o(wc1)
    );

    always #5 clk = ~clk;

    // Reference model: count words seen since arm; word n (n >= SKIP) lands at n-SKIP.
    logic [AW+31:0] q0[$];
    logic [AW+31:0] q1[$];
    logic           m_active, m_done, m_wr;
    int             m_seen, m_wc, m_addr;
    logic [31:0]    m_data;

    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = w[8*k +: 8];
            r[8*k +: 8] = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_wr = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_seen = 0; m_wc = 0; m_addr = 0; m_data = '0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
            end else if (if0.in_valid) begin
                if (m_seen >= SKIP) begin
                    q0.push_back({AW'(m_seen - SKIP), if0.in_data});
                    q1.push_back({AW'(m_seen - SKIP), ref_swap(if0.in_data)});
                    m_wr   = 1'b1;
                    m_addr = m_seen - SKIP;
                    m_data = if0.in_data;
                    m_wc   = m_wc + 1;
                    if (m_wc == TOTAL) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
                m_seen = m_seen + 1;
            end
        end else if (arm && !abort) begin
            m_active = 1'b1; m_done = 1'b0; m_seen = 0; m_wc = 0; m_addr = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic status(input string t, input logic rdy, input logic wr, input logic flip,
                          input logic busy, input logic done, input logic [AW-1:0] wc,
                          input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_data);
        chk({t, " in_ready"},     64'(rdy),  64'(m_active));
        chk({t, " wr_en"},        64'(wr),   64'(m_wr));
        chk({t, " flip_start"},   64'(flip), 64'(m_active));
        chk({t, " busy"},         64'(busy), 64'(m_active));
        chk({t, " capture_done"}, 64'(done), 64'(m_done));
        chk({t, " word_count"},   64'(wc),   64'(AW'(m_wc)));
        chk({t, " write_addr"},   64'(addr), 64'(AW'(m_addr)));
        chk({t, " data_output"},  64'(data), 64'(exp_data));
    endtask

    // Monitor: pop the scoreboard on every write and check all outputs against the model.
    logic [AW+31:0] e0, e1;
    always @(negedge clk) begin
        if (if0.wr_en === 1'b1) begin
            if (q0.size() == 0) chk("u0 spurious wr_en", 64'd1, 64'd0);
            else begin
                e0 = q0.pop_front();
                chk("u0 sb addr", 64'(if0.write_addr), 64'(e0[AW+31:32]));
                chk("u0 sb data", 64'(if0.data_output), 64'(e0[31:0]));
            end
        end
        if (if1.wr_en === 1'b1) begin
            if (q1.size() == 0) chk("u1 spurious wr_en", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("u1 sb addr", 64'(if1.write_addr), 64'(e1[AW+31:32]));
                chk("u1 sb data", 64'(if1.data_output), 64'(e1[31:0]));
            end
        end
        status("u0", if0.in_ready, if0.wr_en, flip0, busy0, done0, wc0,
               if0.write_addr, if0.data_output, m_data);
        status("u1", if1.in_ready, if1.wr_en, flip1, busy1, done1, wc1,
               if1.write_addr, if1.data_output, ref_swap(m_data));
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic a, input logic ab);
        if0.in_valid = v; if1.in_valid = v;
        if0.in_data  = d; if1.in_data  = d;
        arm = a; abort = ab;
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0;
        if0.in_valid = 1'b1; if1.in_valid = 1'b1;
        if0.in_data = 32'hDEAD_BEEF; if1.in_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Back-to-back capture
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        idle(3);

        // Gapped capture, including the byte-swap pattern
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i == 2) ? 32'h0180_0FF0 : 32'hA0 + 32'(i), 1'b0, 1'b0);
            drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        end
        idle(2);

        // Abort with a beat in flight on word 2, then full restart
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hB4, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 32'h0, 1'b1, 1'b1);
        idle(1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);

        // Re-arm from DONE with a stray arm mid-capture
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hD0 + 32'(i), (i == 3), 1'b0);
        idle(2);

        // Reset in the middle of a capture
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 32'hE3, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Randomized captures with occasional stray arm/abort
        for (int r = 0; r < 24; r++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            for (int c = 0; c < 14; c++) begin
                drive($urandom_range(0, 3) != 0, $urandom,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            end
        end
        idle(3);

        chk("u0 scoreboard drained", 64'(q0.size()), 64'd0);
        chk("u1 scoreboard drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
